apb_cmd_master: RTL and testbench

Command-driven APB master that sits directly upstream of the APB register slave (DATA 0x00, CONTROL 0x04, RESULT 0x08 OR-accumulator). It accepts read/write commands over a valid/ready stream and buffers them in a small FIFO. It executes each command as a standard two-phase APB transfer and returns one response (read data + error) per command over a second valid/ready stream. It replaces task-based bus driving so firmware/sequencer logic can issue bus traffic without cycle-level control.

---
 rtl/apb_cmd_pkg.sv | 21 ++
 rtl/apb_cmd_fifo.sv | 50 +++++
 rtl/apb_cmd_master.sv | 122 ++++++++++++
 tb/tb_apb_cmd_master.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_cmd_pkg.sv
// Shared types and default widths for the command-driven APB master.
package apb_cmd_pkg;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 32;
  localparam int DEF_FIFO_DEPTH = 4;
  localparam int DEF_TIMEOUT    = 16;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra MSB so full and empty
// are distinguishable without a separate flag.
module apb_cmd_fifo
  import apb_cmd_pkg::*;
#(
  parameter int DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  cmd_t                     wdata,
  input  logic                     pop,
  output cmd_t                     rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  cmd_t        mem [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign count   = wptr - rptr;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/apb_cmd_master.sv
// Command-stream APB master: queues read/write commands, runs each as a
// two-phase APB transfer with a wait timeout, returns one response per command.
module apb_cmd_master
  import apb_cmd_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  state_t                      state;
  logic [WW-1:0]               wait_cnt;
  cmd_t                        cmd_in;
  cmd_t                        head;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [$clog2(FIFO_DEPTH):0] fifo_count;
  logic                        slot_free;
  logic                        pop;

  assign cmd_in    = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};
  assign cmd_ready = !fifo_full;
  // A new transfer may start only if its response will have somewhere to go.
  assign slot_free = !rsp_valid || rsp_ready;
  assign pop       = (state == IDLE) && !fifo_empty && slot_free;

  apb_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_valid),
    .wdata (cmd_in),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            PADDR    <= head.addr;
            PWRITE   <= head.write;
            PWDATA   <= head.wdata;
            PSEL     <= 1'b1;
            wait_cnt <= '0;
            state    <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_err     <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Scoreboard bench for apb_cmd_master against a behavioural model of the
// DATA/CONTROL/RESULT register slave with controllable wait states.
module tb_apb_cmd_master;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  apb_cmd_master dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .rsp_timeout (rsp_timeout),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PADDR       (PADDR),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .PREADY      (PREADY),
    .PSLVERR     (PSLVERR)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Register slave model: writing CONTROL with bit0 set ORs DATA into RESULT.
  logic [31:0] r_data, r_ctrl, r_result;
  int          stall_left;
  int          stall_cmd;
  logic        load_stall;
  logic        addr_ok;

  assign addr_ok = (PADDR == 8'h00) || (PADDR == 8'h04) || (PADDR == 8'h08);
  assign PREADY  = (stall_left == 0);
  assign PSLVERR = PSEL && PENABLE && PREADY && (!addr_ok || (PWRITE && PADDR == 8'h08));
  assign PRDATA  = (PADDR == 8'h00) ? r_data :
                   (PADDR == 8'h04) ? r_ctrl :
                   (PADDR == 8'h08) ? r_result : 32'h0;

  initial begin
    r_data = '0; r_ctrl = '0; r_result = '0; stall_left = 0;
  end

  always @(posedge clk) begin
    if (load_stall) stall_left <= stall_cmd;
    else if (PSEL && PENABLE) begin
      if (!PREADY) stall_left <= stall_left - 1;
      else if (PWRITE && !PSLVERR) begin
        if (PADDR == 8'h00) r_data <= PWDATA;
        if (PADDR == 8'h04) begin
          r_ctrl <= PWDATA;
          if (PWDATA[0]) r_result <= r_result | r_data;
        end
      end
    end
  end

  // Bus observers: completed transfers and ACCESS length of the last transfer.
  int xfer_cnt = 0;
  int cur_len  = 0;
  int last_len = 0;
  always @(posedge clk) begin
    if (PSEL && PENABLE && PREADY) xfer_cnt <= xfer_cnt + 1;
    if (PSEL && PENABLE) cur_len <= cur_len + 1;
    else if (!PSEL) begin
      if (cur_len != 0) last_len <= cur_len;
      cur_len <= 0;
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rsp: got rdata 0x%08h err %0b, expected no response", rsp_rdata, rsp_err);
      end else begin
        mon_e = sb.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
        check("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.to));
      end
    end
  end

  task automatic send(input logic w, input logic [7:0] a, input logic [31:0] d,
                      input logic exp_rsp, input logic [31:0] er, input logic ee, input logic et);
    bit acc;
    acc = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 100 && !acc; i++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
    end
    #1 cmd_valid = 1'b0;
    check("cmd_accept", 32'(acc), 32'd1);
    if (acc && exp_rsp) sb.push_back('{rdata: er, err: ee, to: et});
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = (sb.size() == 0) && !PSEL && !rsp_valid;
    end
    check("drain", 32'(ok), 32'd1);
  endtask

  task automatic set_stall(input int n);
    stall_cmd = n;
    load_stall = 1'b1;
    @(posedge clk);
    #1 load_stall = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

  int x0;
  bit seen;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b0; load_stall = 1'b0; stall_cmd = 0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_psel", 32'(PSEL), 32'd0);
    check("rst_penable", 32'(PENABLE), 32'd0);
    rsp_ready = 1'b1;

    // Reset-state register reads.
    send(0, 8'h00, 0, 1, 32'h0, 0, 0);
    send(0, 8'h04, 0, 1, 32'h0, 0, 0);
    send(0, 8'h08, 0, 1, 32'h0, 0, 0);
    wait_idle();

    // First accumulate write doubles as the k+1/k+2/k+3 timing check.
    send(1, 8'h00, 32'h0000000C, 1, 32'h0, 0, 0);
    check("t_k_psel", 32'(PSEL), 32'd0);
    @(posedge clk); #1;
    check("t_k1_psel", 32'(PSEL), 32'd1);
    check("t_k1_penable", 32'(PENABLE), 32'd0);
    check("t_k1_paddr", 32'(PADDR), 32'h00);
    check("t_k1_pwrite", 32'(PWRITE), 32'd1);
    @(posedge clk); #1;
    check("t_k2_psel", 32'(PSEL), 32'd1);
    check("t_k2_penable", 32'(PENABLE), 32'd1);
    check("t_k2_pwdata", PWDATA, 32'h0000000C);
    @(posedge clk); #1;
    check("t_k3_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t_k3_psel", 32'(PSEL), 32'd0);
    send(1, 8'h04, 32'h1, 1, 32'h0, 0, 0);
    send(0, 8'h08, 0, 1, 32'h0000000C, 0, 0);
    send(1, 8'h00, 32'h000000B0, 1, 32'h0, 0, 0);
    send(1, 8'h04, 32'h1, 1, 32'h0, 0, 0);
    send(0, 8'h08, 0, 1, 32'h000000BC, 0, 0);
    wait_idle();

    // Slave errors: unmapped address and write to read-only RESULT.
    send(1, 8'h0C, 32'h12345678, 1, 32'h0, 1, 0);
    send(1, 8'h08, 32'hFFFFFFFF, 1, 32'h0, 1, 0);
    wait_idle();

    // Backpressure: one transfer completes, FIFO fills, bus stays idle.
    rsp_ready = 1'b0;
    x0 = xfer_cnt;
    send(1, 8'h00, 32'h11, 1, 32'h0, 0, 0);
    send(0, 8'h00, 0, 1, 32'h11, 0, 0);
    send(1, 8'h00, 32'h22, 1, 32'h0, 0, 0);
    send(0, 8'h00, 0, 1, 32'h22, 0, 0);
    send(0, 8'h08, 0, 1, 32'hBC, 0, 0);
    repeat (8) @(posedge clk);
    #1;
    check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    check("bp_psel", 32'(PSEL), 32'd0);
    check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
    check("bp_xfers", 32'(xfer_cnt - x0), 32'd1);
    rsp_ready = 1'b1;
    wait_idle();

    // Timeout after 16 low ACCESS cycles; next command sees 4 leftover waits.
    set_stall(20);
    send(0, 8'h04, 0, 1, 32'h0, 1, 1);
    wait_idle();
    check("to_access_len", 32'(last_len), 32'd16);
    send(0, 8'h00, 0, 1, 32'h22, 0, 0);
    wait_idle();
    check("post_to_access_len", 32'(last_len), 32'd5);

    // Reset in the middle of a stalled ACCESS with two commands queued.
    set_stall(10);
    send(0, 8'h00, 0, 0, 32'h0, 0, 0);
    send(0, 8'h04, 0, 0, 32'h0, 0, 0);
    send(0, 8'h08, 0, 0, 32'h0, 0, 0);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      seen = PSEL && PENABLE;
    end
    check("rr_in_access", 32'(seen), 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rr_psel", 32'(PSEL), 32'd0);
    check("rr_penable", 32'(PENABLE), 32'd0);
    check("rr_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rr_cmd_ready", 32'(cmd_ready), 32'd1);
    set_stall(0);
    repeat (20) @(posedge clk);
    #1;
    check("rr_quiet_psel", 32'(PSEL), 32'd0);
    check("rr_quiet_rsp", 32'(rsp_valid), 32'd0);
    send(0, 8'h08, 0, 1, 32'hBC, 0, 0);
    wait_idle();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
